// File: rtl/seq_chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder_pkg
//   Shared definitions for the multi-cycle chunked ripple adder:
//   - state_t    : FSM state encoding (IDLE / RUN / DONE)
//   - clog2_min1 : ceiling log2 with a floor of one bit, used to size the
//                  chunk counter and the sum part-select index.
// ---------------------------------------------------------------------------
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns ceil(log2(value)), never less than 1, so a counter for a single
  // chunk still has a legal one-bit vector.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell.
//   Ports: a, b, c_in -> s (sum bit), c_out (carry out).
//
// chunk_ripple_adder #(CHUNK)
//   CHUNK-bit ripple adder built as a generate chain of full_adder cells.
//   Ports: a[CHUNK-1:0], b[CHUNK-1:0], c_in -> s[CHUNK-1:0], c_out (carry out
//   of the top bit), c_msb (carry into the top bit, used for signed overflow).
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module chunk_ripple_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk.
  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (s[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder #(WIDTH, CHUNK)
//   Multi-cycle ripple adder computing in_1 + in_2 + c_in, CHUNK bits per
//   clock, so the combinational carry chain is only CHUNK bits long. The
//   carry between chunks lives in a register. WIDTH must be a multiple of
//   CHUNK; NCHUNK = WIDTH/CHUNK cycles are spent in RUN per operation.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, honoured only in IDLE or DONE
//   in_1      operand A, captured on the accepting edge
//   in_2      operand B, captured on the accepting edge
//   c_in      carry in, captured on the accepting edge
//   busy      high while the FSM is in RUN
//   done      one-cycle pulse, result valid
//   sum       WIDTH-bit result
//   c_out     carry out of bit WIDTH-1
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = clog2_min1(NCHUNK);
  localparam int IDX_W  = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             chunk_c_out;
  logic             chunk_c_msb;
  logic             accept;

  // A new request is taken from IDLE, or straight out of DONE so that
  // back-to-back operations lose no cycle.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Bit offset of the chunk currently being added; the same offset selects
  // the operand slices and the destination slice of sum.
  assign base    = IDX_W'(int'(count) * CHUNK);
  assign a_chunk = op_a[base +: CHUNK];
  assign b_chunk = op_b[base +: CHUNK];

  chunk_ripple_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .c_in  (carry),
    .s     (s_chunk),
    .c_out (chunk_c_out),
    .c_msb (chunk_c_msb)
  );

  // State register plus datapath registers. On acceptance the operands and
  // carry are latched and the result is cleared; in RUN one chunk is written
  // per edge, and the final chunk also produces c_out and overflow. The
  // counter holds at its last value rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a  <= in_1;
        op_b  <= in_2;
        carry <= c_in;
        count <= '0;
        sum   <= '0;
      end else if (state == S_RUN) begin
        sum[base +: CHUNK] <= s_chunk;
        carry              <= chunk_c_out;
        if (count == LAST) begin
          c_out    <= chunk_c_out;
          overflow <= chunk_c_out ^ chunk_c_msb;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // Next-state logic and state decodes for busy/done.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Drives four seq_chunk_adder instances (WIDTH=8, CHUNK = 1, 2, 4, 8) from
//   shared inputs and compares them against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  localparam int NCH [4] = '{8, 4, 2, 1};

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in_1;
  logic [7:0] in_2;
  logic       c_in;

  logic       busy_w     [4];
  logic       done_w     [4];
  logic [7:0] sum_w      [4];
  logic       c_out_w    [4];
  logic       overflow_w [4];

  int total = 0;
  int bad   = 0;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2), .c_in(c_in),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .c_out(c_out_w[0]),
    .overflow(overflow_w[0])
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2), .c_in(c_in),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .c_out(c_out_w[1]),
    .overflow(overflow_w[1])
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2), .c_in(c_in),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .c_out(c_out_w[2]),
    .overflow(overflow_w[2])
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2), .c_in(c_in),
    .busy(busy_w[3]), .done(done_w[3]), .sum(sum_w[3]), .c_out(c_out_w[3]),
    .overflow(overflow_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full operation on all four instances: operands presented before edge 0,
  // scrambled afterwards, then observed on the falling edge after edges 0..9.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input bit check_timing);
    logic [8:0] ref_full;
    logic       ref_ovf;
    int         done_cnt  [4];
    int         done_edge [4];
    ref_full = 9'(a) + 9'(b) + 9'(c);
    ref_ovf  = (a[7] == b[7]) && (ref_full[7] != a[7]);
    for (int i = 0; i < 4; i++) begin
      done_cnt[i]  = 0;
      done_edge[i] = -1;
    end
    @(negedge clk);
    in_1  = a;
    in_2  = b;
    c_in  = c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_1  = 8'($urandom);
    in_2  = 8'($urandom);
    c_in  = 1'($urandom);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          done_cnt[i]++;
          done_edge[i] = k;
          check_output($sformatf("sum[%0d] %h+%h+%0d", i, a, b, c), 32'(sum_w[i]), 32'(ref_full[7:0]));
          check_output($sformatf("c_out[%0d] %h+%h+%0d", i, a, b, c), 32'(c_out_w[i]), 32'(ref_full[8]));
          check_output($sformatf("overflow[%0d] %h+%h+%0d", i, a, b, c), 32'(overflow_w[i]), 32'(ref_ovf));
        end
        if (check_timing) begin
          check_output($sformatf("busy[%0d] edge %0d", i, k), 32'(busy_w[i]), 32'(k < NCH[i]));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("done_count[%0d]", i), 32'(done_cnt[i]), 32'd1);
      check_output($sformatf("done_edge[%0d]", i), 32'(done_edge[i]), 32'(NCH[i]));
    end
  endtask

  initial begin
    int n_done;

    rst_n = 1'b0;
    start = 1'b0;
    in_1  = 8'h00;
    in_2  = 8'h00;
    c_in  = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("rst busy[%0d]", i), 32'(busy_w[i]), 32'd0);
      check_output($sformatf("rst done[%0d]", i), 32'(done_w[i]), 32'd0);
      check_output($sformatf("rst sum[%0d]", i), 32'(sum_w[i]), 32'd0);
      check_output($sformatf("rst c_out[%0d]", i), 32'(c_out_w[i]), 32'd0);
      check_output($sformatf("rst overflow[%0d]", i), 32'(overflow_w[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed arithmetic");
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    apply_stimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    apply_stimulus(8'h80, 8'h80, 1'b0, 1'b1);
    apply_stimulus(8'h00, 8'h00, 1'b1, 1'b1);
    apply_stimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
    apply_stimulus(8'h12, 8'h34, 1'b0, 1'b1);

    $display("[TB] start while running is ignored");
    @(negedge clk);
    in_1  = 8'h10;
    in_2  = 8'h20;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_1  = 8'hFF;
    in_2  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    check_output("t4 busy after re-pulse", 32'(busy_w[1]), 32'd1);
    for (int k = 2; k <= 9; k++) begin
      if (k > 2) @(negedge clk);
      if (done_w[1]) begin
        n_done++;
        check_output("t4 sum", 32'(sum_w[1]), 32'h30);
        check_output("t4 done edge", 32'(k), 32'd4);
      end
    end
    check_output("t4 done count", 32'(n_done), 32'd1);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-operation");
    in_1  = 8'h0F;
    in_2  = 8'h00;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("t5 busy", 32'(busy_w[1]), 32'd0);
    check_output("t5 done", 32'(done_w[1]), 32'd0);
    check_output("t5 sum", 32'(sum_w[1]), 32'd0);
    check_output("t5 c_out", 32'(c_out_w[1]), 32'd0);
    check_output("t5 overflow", 32'(overflow_w[1]), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (done_w[i]) n_done++;
    end
    check_output("t5 no done after reset", 32'(n_done), 32'd0);
    apply_stimulus(8'h03, 8'h04, 1'b0, 1'b1);

    $display("[TB] back-to-back start");
    @(negedge clk);
    in_1  = 8'h12;
    in_2  = 8'h34;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("b2b busy e0", 32'(busy_w[3]), 32'd1);
    check_output("b2b done e0", 32'(done_w[3]), 32'd0);
    @(negedge clk);
    check_output("b2b done e1", 32'(done_w[3]), 32'd1);
    check_output("b2b sum e1", 32'(sum_w[3]), 32'h46);
    in_1 = 8'h01;
    in_2 = 8'h02;
    @(negedge clk);
    check_output("b2b done e2", 32'(done_w[3]), 32'd0);
    check_output("b2b busy e2", 32'(busy_w[3]), 32'd1);
    @(negedge clk);
    check_output("b2b done e3", 32'(done_w[3]), 32'd1);
    check_output("b2b sum e3", 32'(sum_w[3]), 32'h03);
    start = 1'b0;
    @(negedge clk);
    check_output("b2b done e4", 32'(done_w[3]), 32'd0);
    check_output("b2b busy e4", 32'(busy_w[3]), 32'd0);
    check_output("b2b c2 done e4", 32'(done_w[1]), 32'd1);
    check_output("b2b c2 sum e4", 32'(sum_w[1]), 32'h46);
    repeat (10) @(negedge clk);

    $display("[TB] randomised operations");
    for (int n = 0; n < 1000; n++) begin
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), (n < 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
